// File: rtl/window_shade_actuator.sv
// Window-shade motor actuator: latches a requested shade level, steps the motor
// one level per STEP_DIV cycles toward it, then waits a settle time before done.
module window_shade_actuator #(
  parameter int STEP_DIV      = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] target,
  input  logic       target_valid,
  output logic       motor_up,
  output logic       motor_down,
  output logic [3:0] position,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, MOVE, SETTLE} state_t;

  localparam int PW = $clog2(STEP_DIV);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [PW-1:0] PRE_LAST    = PW'(STEP_DIV - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  state_t        state_q, state_d;
  logic [3:0]    pos_q, pos_d;
  logic [3:0]    tgt_q, tgt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          up_q, up_d;
  logic          down_q, down_d;
  logic          done_q, done_d;
  logic          busy_q;
  logic          step_now;

  // NOTE: every _d gets a default before the case so no path leaves a latch.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    tgt_d    = tgt_q;
    pre_d    = pre_q;
    settle_d = settle_q;
    up_d     = 1'b0;
    down_d   = 1'b0;
    done_d   = 1'b0;
    step_now = (state_q == MOVE) && (pre_q == PRE_LAST) && (pos_q != tgt_q);

    case (state_q)
      IDLE: begin
        if (target_valid) begin
          tgt_d = target;
          if (target != pos_q) begin
            state_d = MOVE;
            pre_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      MOVE: begin
        pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        if (target_valid) tgt_d = target;
        if (step_now) begin
          // Direction follows the target latched before this edge.
          if (tgt_q > pos_q) begin
            up_d  = 1'b1;
            pos_d = pos_q + 4'd1;
          end else begin
            down_d = 1'b1;
            pos_d  = pos_q - 4'd1;
          end
          if (!target_valid && (pos_d == tgt_q)) begin
            state_d  = SETTLE;
            settle_d = '0;
          end
        end else if (tgt_d == pos_q) begin
          state_d  = SETTLE;
          settle_d = '0;
        end
      end

      SETTLE: begin
        if (target_valid) begin
          tgt_d = target;
          if (target != pos_q) begin
            state_d = MOVE;
            pre_d   = '0;
          end else begin
            settle_d = '0;
          end
        end else if (settle_q == SETTLE_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      tgt_q    <= '0;
      pre_q    <= '0;
      settle_q <= '0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      tgt_q    <= tgt_d;
      pre_q    <= pre_d;
      settle_q <= settle_d;
      up_q     <= up_d;
      down_q   <= down_d;
      done_q   <= done_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign motor_up   = up_q;
  assign motor_down = down_q;
  assign position   = pos_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_window_shade_actuator.sv
// Directed bench for window_shade_actuator: a cycle table for the first request,
// then hand-written sequences for reverse moves, retargets and mid-move reset.
module tb_window_shade_actuator;

  localparam int STEP_DIV      = 4;
  localparam int SETTLE_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] target;
  logic       target_valid;
  logic       motor_up, motor_down, busy, done;
  logic [3:0] position;

  int checks   = 0;
  int failures = 0;

  window_shade_actuator #(.STEP_DIV(STEP_DIV), .SETTLE_CYCLES(SETTLE_CYCLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .target       (target),
    .target_valid (target_valid),
    .motor_up     (motor_up),
    .motor_down   (motor_down),
    .position     (position),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       tv;
    logic [3:0] tgt;
    logic       chk;
    logic       up;
    logic       down;
    logic       busy;
    logic       done;
    logic [3:0] pos;
  } vec_t;

  vec_t vecs[27];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got up,down,busy,done,pos=%b required %b", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic e_up, input logic e_down,
                            input logic e_busy, input logic e_done, input logic [3:0] e_pos);
    check(name, {motor_up, motor_down, busy, done, position},
                {e_up, e_down, e_busy, e_done, e_pos});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe a request from idle and check every cycle against the documented timing.
  task automatic req_and_check(input string name, input logic [3:0] tgt, input logic [3:0] start);
    int         n_steps, last, steps;
    logic       dir_up, pulse;
    logic [3:0] e_pos;
    dir_up  = tgt > start;
    n_steps = dir_up ? int'(tgt) - int'(start) : int'(start) - int'(tgt);
    last    = (n_steps == 0) ? 1 : n_steps * STEP_DIV + SETTLE_CYCLES + 1;
    target_valid = 1'b1;
    target       = tgt;
    expect_out($sformatf("%s_d0", name), 1'b0, 1'b0, 1'b0, 1'b0, start);
    tick();
    target_valid = 1'b0;
    for (int d = 1; d <= last + 1; d++) begin
      steps = (d - 1) / STEP_DIV;
      if (steps > n_steps) steps = n_steps;
      e_pos = dir_up ? start + 4'(steps) : start - 4'(steps);
      pulse = (n_steps > 0) && (d >= STEP_DIV + 1) && ((d - 1) % STEP_DIV == 0)
              && ((d - 1) / STEP_DIV <= n_steps);
      expect_out($sformatf("%s_d%0d", name, d), pulse && dir_up, pulse && !dir_up,
                 (n_steps > 0) && (d <= last - 1), d == last, e_pos);
      tick();
    end
  endtask

  initial begin
    logic [3:0] e_pos;
    rst          = 1'b1;
    target_valid = 1'b0;
    target       = 4'd0;

    // Scenario 1: reset, then target 3 strobed in cycle 10.
    for (int n = 0; n < 27; n++) begin
      if (n >= 23)      e_pos = 4'd3;
      else if (n >= 19) e_pos = 4'd2;
      else if (n >= 15) e_pos = 4'd1;
      else              e_pos = 4'd0;
      vecs[n] = '{rst: (n < 2), tv: 1'b0, tgt: 4'd0, chk: (n >= 1),
                  up: (n == 15 || n == 19 || n == 23), down: 1'b0,
                  busy: (n >= 11 && n <= 24), done: (n == 25), pos: e_pos};
    end
    vecs[10].tv  = 1'b1;
    vecs[10].tgt = 4'd3;

    for (int n = 0; n < 27; n++) begin
      rst          = vecs[n].rst;
      target_valid = vecs[n].tv;
      target       = vecs[n].tgt;
      if (vecs[n].chk)
        expect_out($sformatf("s1_c%0d", n), vecs[n].up, vecs[n].down,
                   vecs[n].busy, vecs[n].done, vecs[n].pos);
      tick();
    end
    target_valid = 1'b0;

    // Scenario 2: 3 -> 0, three downward steps.
    req_and_check("s2", 4'd0, 4'd3);

    // Scenario 3: target equals position.
    req_and_check("s3", 4'd0, 4'd0);

    // Scenario 4: 0 -> 15, retarget to 5 the cycle after position reaches 7.
    target_valid = 1'b1;
    target       = 4'd15;
    expect_out("s4_d0", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    for (int d = 1; d <= 40; d++) begin
      target_valid = (d == 30);
      target       = 4'd5;
      if (d >= 37)      e_pos = 4'd5;
      else if (d >= 33) e_pos = 4'd6;
      else              e_pos = ((d - 1) / 4 > 7) ? 4'd7 : 4'((d - 1) / 4);
      expect_out($sformatf("s4_d%0d", d), (d >= 5) && (d <= 29) && ((d - 1) % 4 == 0),
                 (d == 33) || (d == 37), d <= 38, d == 39, e_pos);
      tick();
    end
    target_valid = 1'b0;

    // Request equal to the current non-zero position.
    req_and_check("s4b", 4'd5, 4'd5);

    // Scenario 5: 5 -> 4, then retarget to 8 during SETTLE.
    for (int d = 0; d <= 26; d++) begin
      target_valid = (d == 0) || (d == 6);
      target       = (d == 0) ? 4'd4 : 4'd8;
      if (d < 5)       e_pos = 4'd5;
      else if (d < 11) e_pos = 4'd4;
      else             e_pos = 4'd5 + 4'((d - 11) / 4);
      expect_out($sformatf("s5_d%0d", d),
                 (d == 11) || (d == 15) || (d == 19) || (d == 23), d == 5,
                 (d >= 1) && (d <= 24), d == 25, e_pos);
      tick();
    end
    target_valid = 1'b0;

    // Scenario 6: 8 -> 0, reset asserted while at position 6.
    for (int d = 0; d <= 11; d++) begin
      target_valid = (d == 0);
      target       = 4'd0;
      rst          = (d == 10);
      if (d < 5)       e_pos = 4'd8;
      else if (d < 9)  e_pos = 4'd7;
      else if (d < 11) e_pos = 4'd6;
      else             e_pos = 4'd0;
      expect_out($sformatf("s6_d%0d", d), 1'b0, (d == 5) || (d == 9),
                 (d >= 1) && (d <= 10), 1'b0, e_pos);
      tick();
    end
    rst          = 1'b0;
    target_valid = 1'b0;

    // After reset a fresh request behaves like the first one.
    req_and_check("s6b", 4'd3, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
